// File: rtl/fft8_bitrev_reader.sv
// 8-point FFT input reorder buffer: fills eight samples in natural order,
// then drains them in bit-reversed address order with valid/ready handshakes.
module fft8_bitrev_reader #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sclr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          block_done
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state;
  logic [2:0]    wr_cnt;
  logic [2:0]    rd_cnt;
  logic [DW-1:0] mem [8];
  logic          wr_fire;
  logic          rd_fire;

  // Handshake outputs decode from state only; no path from in_valid/out_ready.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (rd_cnt == 3'd7);
  assign out_idx   = rd_cnt;
  assign out_data  = mem[{rd_cnt[0], rd_cnt[1], rd_cnt[2]}];

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      block_done <= 1'b0;
    end else if (sclr) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= rd_fire && (rd_cnt == 3'd7);
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 3'd1;
        if (wr_cnt == 3'd7) begin
          state  <= DRAIN;
          rd_cnt <= '0;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 3'd1;
        if (rd_cnt == 3'd7)
          state <= FILL;
      end
    end
  end

  // Storage is retained across sclr; only aclr or an accepted write changes it.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned i = 0; i < 8; i++)
        mem[i] <= '0;
    end else if (wr_fire && !sclr) begin
      mem[wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft8_bitrev_reader.sv
// Directed self-checking bench for fft8_bitrev_reader.
module tb_fft8_bitrev_reader;

  logic        clk;
  logic        aclr;
  logic        sclr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        block_done;

  int n_cmp = 0;
  int n_err = 0;
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft8_bitrev_reader #(.DW(16)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .sclr       (sclr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writes base..base+7; entered and left on a falling edge.
  task automatic fill_block(input logic [15:0] base, input string tag);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL %s fill in_ready[%0d]: got %b want 1", tag, i, in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL %s fill out_valid[%0d]: got %b want 0", tag, i, out_valid);
      end
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL %s out_valid after fill: got %b want 1", tag, out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL %s in_ready after fill: got %b want 0", tag, in_ready);
    end
  endtask

  // Drains beats from start_idx with out_ready=1, expecting base+bitrev(idx).
  task automatic drain_check(input logic [15:0] base, input int start_idx, input string tag);
    out_ready = 1'b1;
    for (int i = start_idx; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL %s out_valid[%0d]: got %b want 1", tag, i, out_valid);
      end
      n_cmp++;
      if (out_data !== base + 16'(br[i])) begin
        n_err++; $display("FAIL %s out_data[%0d]: got %h want %h", tag, i, out_data, base + 16'(br[i]));
      end
      n_cmp++;
      if (out_idx !== 3'(i)) begin
        n_err++; $display("FAIL %s out_idx[%0d]: got %0d want %0d", tag, i, out_idx, i);
      end
      n_cmp++;
      if (out_last !== (i == 7)) begin
        n_err++; $display("FAIL %s out_last[%0d]: got %b want %b", tag, i, out_last, (i == 7));
      end
      n_cmp++;
      if (block_done !== 1'b0) begin
        n_err++; $display("FAIL %s early block_done[%0d]: got %b want 0", tag, i, block_done);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (block_done !== 1'b1) begin
      n_err++; $display("FAIL %s block_done: got %b want 1", tag, block_done);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s after drain in_ready/out_valid: got %b%b want 10", tag, in_ready, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (block_done !== 1'b0) begin
      n_err++; $display("FAIL %s block_done width: got %b want 0", tag, block_done);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_err++; $display("FAIL reset handshake: got ir=%b ov=%b ol=%b want 1 0 0", in_ready, out_valid, out_last);
    end
    n_cmp++;
    if (out_idx !== 3'd0 || out_data !== 16'h0 || block_done !== 1'b0) begin
      n_err++; $display("FAIL reset data: got idx=%0d data=%h done=%b want 0 0000 0", out_idx, out_data, block_done);
    end
    aclr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bitrev();
    out_ready = 1'b1;
    fill_block(16'h0010, "bitrev");
    drain_check(16'h0010, 0, "bitrev");
  endtask

  task automatic test_stall();
    fill_block(16'h0010, "stall");
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_data !== 16'h0016 || out_idx !== 3'd3) begin
        n_err++; $display("FAIL stall hold[%0d]: got data=%h idx=%0d want 0016 3", c, out_data, out_idx);
      end
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0) begin
        n_err++; $display("FAIL stall flags[%0d]: got ir=%b ov=%b ol=%b want 0 1 0", c, in_ready, out_valid, out_last);
      end
    end
    drain_check(16'h0010, 3, "stall");
  endtask

  task automatic test_ignore_in_drain();
    fill_block(16'h0030, "ignore");
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    drain_check(16'h0030, 0, "ignore");
    fill_block(16'h0040, "ignore_next");
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    drain_check(16'h0040, 0, "ignore_next");
  endtask

  task automatic test_sclr();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0050 + 16'(i);
      @(negedge clk);
    end
    sclr     = 1'b1;
    in_data  = 16'h00EE;
    @(negedge clk);
    sclr     = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL sclr fill: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    fill_block(16'h0020, "sclr");
    drain_check(16'h0020, 0, "sclr");
    // Clear mid-drain, with a read beat offered on the clearing edge.
    fill_block(16'h0060, "sclr_drain");
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || block_done !== 1'b0) begin
      n_err++; $display("FAIL sclr drain: got ir=%b ov=%b done=%b want 1 0 0", in_ready, out_valid, block_done);
    end
    fill_block(16'h0070, "sclr_refill");
    drain_check(16'h0070, 0, "sclr_refill");
  endtask

  task automatic test_aclr();
    fill_block(16'h0080, "aclr");
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_idx !== 3'd4 || out_data !== 16'h0081) begin
      n_err++; $display("FAIL aclr pre: got idx=%0d data=%h want 4 0081", out_idx, out_data);
    end
    out_ready = 1'b0;
    #2 aclr = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL aclr async flags: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_data !== 16'h0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_err++; $display("FAIL aclr async data: got data=%h idx=%0d ol=%b want 0000 0 0", out_data, out_idx, out_last);
    end
    @(negedge clk);
    aclr = 1'b0;
    fill_block(16'h0090, "aclr_refill");
    drain_check(16'h0090, 0, "aclr_refill");
  endtask

  task automatic test_back_to_back();
    int wcount = 0;
    int rcount = 0;
    int dones  = 0;
    logic [15:0] exp;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (block_done === 1'b1) dones++;
      if (out_valid === 1'b1) begin
        exp = 16'h00A0 + 16'((rcount / 8) * 8 + br[rcount % 8]);
        n_cmp++;
        if (out_data !== exp || out_idx !== 3'(rcount % 8)) begin
          n_err++; $display("FAIL b2b beat %0d: got data=%h idx=%0d want %h %0d", rcount, out_data, out_idx, exp, rcount % 8);
        end
        rcount++;
      end
      in_data = 16'h00A0 + 16'(wcount);
      if (in_ready === 1'b1) wcount++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (block_done === 1'b1) dones++;
    n_cmp++;
    if (dones !== 3 || rcount !== 24 || wcount !== 24) begin
      n_err++; $display("FAIL b2b counts: got done=%0d rd=%0d wr=%0d want 3 24 24", dones, rcount, wcount);
    end
    n_cmp++;
    if (block_done !== 1'b1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b 48-cycle end: got done=%b ir=%b want 1 1", block_done, in_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    aclr      = 1'b0;
    sclr      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1 aclr = 1'b1;
    @(negedge clk);
    test_reset();
    test_bitrev();
    test_stall();
    test_ignore_in_drain();
    test_sclr();
    test_aclr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
